// File: rtl/scroll_controller_if.sv
// Pushbutton inputs and display-side outputs of the scrolling word display controller.
// The master side drives the keys; the slave side is the controller itself.
interface scroll_controller_if;
  logic       key_left_n;
  logic       key_right_n;
  logic       key_mode_n;
  logic [2:0] position;
  logic       auto_active;
  logic       dir_right;
  logic       step_pulse;

  modport master (
    output key_left_n, key_right_n, key_mode_n,
    input  position, auto_active, dir_right, step_pulse
  );

  modport slave (
    input  key_left_n, key_right_n, key_mode_n,
    output position, auto_active, dir_right, step_pulse
  );
endinterface

// File: rtl/scroll_controller.sv
// Single-clock scroll sequencer: turns pushbutton presses into a 0..POS_MAX index,
// with manual stepping and a timed auto-scroll mode in either direction.
module scroll_controller #(
  parameter int TICK_DIV = 25000000,
  parameter int POS_MAX  = 5
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  scroll_controller_if.slave bus
);
  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_ONE = PW'(1);
  localparam logic [2:0]     POS_TOP   = 3'(POS_MAX);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO_L = 2'd1;
  localparam logic [1:0] ST_AUTO_R = 2'd2;

  function automatic logic [2:0] pos_inc(input logic [2:0] p);
    if (p == POS_TOP) pos_inc = 3'd0;
    else              pos_inc = p + 3'd1;
  endfunction

  function automatic logic [2:0] pos_dec(input logic [2:0] p);
    if (p == 3'd0) pos_dec = POS_TOP;
    else           pos_dec = p - 3'd1;
  endfunction

  // Key bit order in the pipeline vectors: [0]=left, [1]=right, [2]=mode.
  logic [2:0]    key_s1_r, key_s2_r, key_s3_r;
  logic [2:0]    press_s;
  logic          press_left_s, press_right_s, press_mode_s;
  logic [1:0]    state_r, state_nxt_s;
  logic [2:0]    position_r, pos_nxt_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic          tick_s;
  logic          auto_active_r, dir_right_r, step_pulse_r;

  // Synchronise the asynchronous keys and keep one extra stage for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_s1_r <= 3'b000;
      key_s2_r <= 3'b000;
      key_s3_r <= 3'b000;
    end else begin
      key_s1_r <= {bus.key_mode_n, bus.key_right_n, bus.key_left_n};
      key_s2_r <= key_s1_r;
      key_s3_r <= key_s2_r;
    end
  end

  // A press is the high-to-low transition; resetting to "pressed" hides keys held through reset.
  assign press_s       = ~key_s2_r & key_s3_r;
  assign press_left_s  = press_s[0];
  assign press_right_s = press_s[1];
  assign press_mode_s  = press_s[2];
  assign tick_s        = (state_r != ST_MANUAL) && (presc_r == TICK_LAST);

  // Next state and position; mode press dominates, and a state change suppresses a coincident tick.
  always_comb begin
    state_nxt_s = state_r;
    pos_nxt_s   = position_r;
    case (state_r)
      ST_MANUAL: begin
        if (press_mode_s)                        state_nxt_s = ST_AUTO_L;
        else if (press_left_s && !press_right_s) pos_nxt_s   = pos_inc(position_r);
        else if (press_right_s && !press_left_s) pos_nxt_s   = pos_dec(position_r);
        else                                     pos_nxt_s   = position_r;
      end
      ST_AUTO_L: begin
        if (press_mode_s)                        state_nxt_s = ST_AUTO_R;
        else if (press_right_s && !press_left_s) state_nxt_s = ST_AUTO_R;
        else if (tick_s)                         pos_nxt_s   = pos_inc(position_r);
        else                                     pos_nxt_s   = position_r;
      end
      ST_AUTO_R: begin
        if (press_mode_s)                        state_nxt_s = ST_MANUAL;
        else if (press_left_s && !press_right_s) state_nxt_s = ST_AUTO_L;
        else if (tick_s)                         pos_nxt_s   = pos_dec(position_r);
        else                                     pos_nxt_s   = position_r;
      end
      default: begin
        state_nxt_s = ST_MANUAL;
        pos_nxt_s   = 3'd0;
      end
    endcase
  end

  // Prescaler restarts on any state change so each AUTO entry gets a full interval.
  always_comb begin
    presc_nxt_s = presc_r;
    if ((state_nxt_s != state_r) || (state_r == ST_MANUAL)) presc_nxt_s = '0;
    else if (tick_s)                                        presc_nxt_s = '0;
    else                                                    presc_nxt_s = presc_r + PRESC_ONE;
  end

  // State, position, prescaler and the registered output decodes.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r       <= ST_MANUAL;
      position_r    <= 3'd0;
      presc_r       <= '0;
      auto_active_r <= 1'b0;
      dir_right_r   <= 1'b0;
      step_pulse_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      position_r    <= pos_nxt_s;
      presc_r       <= presc_nxt_s;
      auto_active_r <= (state_nxt_s == ST_AUTO_L) || (state_nxt_s == ST_AUTO_R);
      dir_right_r   <= (state_nxt_s == ST_AUTO_R);
      step_pulse_r  <= (pos_nxt_s != position_r);
    end
  end

  assign bus.position    = position_r;
  assign bus.auto_active = auto_active_r;
  assign bus.dir_right   = dir_right_r;
  assign bus.step_pulse  = step_pulse_r;
endmodule

// File: tb/tb_scroll_controller.sv
// Self-checking bench for scroll_controller: directed scenarios plus a randomized run
// compared against an event-level reference model of the scroll rules.
module tb_scroll_controller;
  localparam int TICK_DIV = 4;
  localparam int POS_MAX  = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  scroll_controller_if bus();

  scroll_controller #(.TICK_DIV(TICK_DIV), .POS_MAX(POS_MAX)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a key level seen low at edge M-2 after high at M-3 is a press acting at edge M.
  logic [2:0] h1, h2, h3;
  int         m_mode, m_pos, m_elapsed;
  bit         m_step;

  always @(posedge clk) begin : model
    logic [2:0] pr;
    int nmode, npos, nel;
    if (reset) begin
      h1 <= 3'b000; h2 <= 3'b000; h3 <= 3'b000;
      m_mode <= 0; m_pos <= 0; m_elapsed <= 0; m_step <= 1'b0;
    end else begin
      pr    = ~h2 & h3;
      nmode = m_mode;
      npos  = m_pos;
      nel   = m_elapsed + 1;
      if (pr[2]) nmode = (m_mode + 1) % 3;
      else if (pr[0] && !pr[1]) begin
        if (m_mode == 0)      npos  = (m_pos + 1) % (POS_MAX + 1);
        else if (m_mode == 2) nmode = 1;
      end else if (pr[1] && !pr[0]) begin
        if (m_mode == 0)      npos  = (m_pos + POS_MAX) % (POS_MAX + 1);
        else if (m_mode == 1) nmode = 2;
      end
      if (nmode != m_mode || m_mode == 0) nel = 0;
      else if (nel == TICK_DIV) begin
        nel  = 0;
        npos = (m_mode == 1) ? (m_pos + 1) % (POS_MAX + 1) : (m_pos + POS_MAX) % (POS_MAX + 1);
      end
      m_mode    <= nmode;
      m_pos     <= npos;
      m_elapsed <= nel;
      m_step    <= (npos != m_pos);
      h3 <= h2;
      h2 <= h1;
      h1 <= {bus.key_mode_n, bus.key_right_n, bus.key_left_n};
    end
  end

  task automatic set_keys(input logic [2:0] low_mask);
    bus.key_left_n  = ~low_mask[0];
    bus.key_right_n = ~low_mask[1];
    bus.key_mode_n  = ~low_mask[2];
  endtask

  // Press the masked keys so they are sampled low at edge N; returns #1 after edge N+2.
  task automatic pulse_keys(input logic [2:0] m);
    @(negedge clk); set_keys(m);
    @(posedge clk); @(posedge clk);
    @(negedge clk); set_keys(3'b000);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_keys(3'b000);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.position !== 3'd0 || bus.auto_active !== 1'b0 || bus.dir_right !== 1'b0 || bus.step_pulse !== 1'b0) begin
        $display("FAIL reset_idle cyc=%0d pos=%0d auto=%b dir=%b step=%b required 0/0/0/0",
                 c, bus.position, bus.auto_active, bus.dir_right, bus.step_pulse);
        failures++;
      end
    end
  endtask

  task automatic test_manual();
    logic [2:0] exp_tab [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd5};
    logic [2:0] prev = 3'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); set_keys(i < 6 ? 3'b001 : 3'b010);
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (bus.position !== prev || bus.step_pulse !== 1'b0) begin
        $display("FAIL manual_early i=%0d pos=%0d step=%b required %0d/0", i, bus.position, bus.step_pulse, prev);
        failures++;
      end
      @(negedge clk); set_keys(3'b000);
      @(posedge clk); #1;
      checks++;
      if (bus.position !== exp_tab[i] || bus.step_pulse !== 1'b1) begin
        $display("FAIL manual_step i=%0d pos=%0d step=%b required %0d/1", i, bus.position, bus.step_pulse, exp_tab[i]);
        failures++;
      end
      @(posedge clk); #1;
      checks++;
      if (bus.step_pulse !== 1'b0 || bus.position !== exp_tab[i]) begin
        $display("FAIL manual_single i=%0d pos=%0d step=%b required %0d/0", i, bus.position, bus.step_pulse, exp_tab[i]);
        failures++;
      end
      prev = exp_tab[i];
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk); set_keys(3'b011);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.position !== 3'd5 || bus.step_pulse !== 1'b0) begin
        $display("FAIL left_right_together cyc=%0d pos=%0d step=%b required 5/0", c, bus.position, bus.step_pulse);
        failures++;
      end
    end
    @(negedge clk); set_keys(3'b000);
    repeat (3) @(posedge clk);
    pulse_keys(3'b101);
    checks++;
    if (bus.auto_active !== 1'b1 || bus.dir_right !== 1'b0 || bus.position !== 3'd5 || bus.step_pulse !== 1'b0) begin
      $display("FAIL mode_left_together auto=%b dir=%b pos=%0d step=%b required 1/0/5/0",
               bus.auto_active, bus.dir_right, bus.position, bus.step_pulse);
      failures++;
    end
    pulse_keys(3'b100);
    pulse_keys(3'b100);
    checks++;
    if (bus.auto_active !== 1'b0 || bus.position !== 3'd5) begin
      $display("FAIL back_to_manual auto=%b pos=%0d required 0/5", bus.auto_active, bus.position);
      failures++;
    end
  endtask

  task automatic test_auto();
    logic [2:0] exp;
    pulse_keys(3'b010);
    pulse_keys(3'b010);
    checks++;
    if (bus.position !== 3'd3) begin
      $display("FAIL auto_setup pos=%0d required 3", bus.position);
      failures++;
    end
    pulse_keys(3'b100);
    checks++;
    if (bus.auto_active !== 1'b1 || bus.dir_right !== 1'b0 || bus.position !== 3'd3) begin
      $display("FAIL auto_l_entry auto=%b dir=%b pos=%0d required 1/0/3", bus.auto_active, bus.dir_right, bus.position);
      failures++;
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp = 3'((3 + k / TICK_DIV) % (POS_MAX + 1));
      checks++;
      if (bus.position !== exp || bus.step_pulse !== ((k % TICK_DIV) == 0)) begin
        $display("FAIL auto_l_step k=%0d pos=%0d step=%b required %0d/%0b", k, bus.position, bus.step_pulse, exp, (k % TICK_DIV) == 0);
        failures++;
      end
    end
    pulse_keys(3'b010);
    checks++;
    if (bus.auto_active !== 1'b1 || bus.dir_right !== 1'b1 || bus.position !== 3'd0 || bus.step_pulse !== 1'b0) begin
      $display("FAIL auto_r_entry auto=%b dir=%b pos=%0d step=%b required 1/1/0/0",
               bus.auto_active, bus.dir_right, bus.position, bus.step_pulse);
      failures++;
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      exp = (k == 4) ? 3'd5 : 3'd0;
      checks++;
      if (bus.position !== exp || bus.step_pulse !== (k == 4)) begin
        $display("FAIL auto_r_step k=%0d pos=%0d step=%b required %0d/%0b", k, bus.position, bus.step_pulse, exp, k == 4);
        failures++;
      end
    end
    // Left press timed so that its state change lands on the cycle a tick would step.
    @(negedge clk);
    @(posedge clk);
    pulse_keys(3'b001);
    checks++;
    if (bus.auto_active !== 1'b1 || bus.dir_right !== 1'b0 || bus.position !== 3'd5 || bus.step_pulse !== 1'b0) begin
      $display("FAIL tick_collision auto=%b dir=%b pos=%0d step=%b required 1/0/5/0",
               bus.auto_active, bus.dir_right, bus.position, bus.step_pulse);
      failures++;
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      exp = (k == 4) ? 3'd0 : 3'd5;
      checks++;
      if (bus.position !== exp || bus.step_pulse !== (k == 4)) begin
        $display("FAIL collision_restart k=%0d pos=%0d step=%b required %0d/%0b", k, bus.position, bus.step_pulse, exp, k == 4);
        failures++;
      end
    end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_ad [3] = '{2'b10, 2'b11, 2'b00};
    pulse_keys(3'b100);
    pulse_keys(3'b100);
    checks++;
    if (bus.auto_active !== 1'b0 || bus.dir_right !== 1'b0) begin
      $display("FAIL mode_cycle_start auto=%b dir=%b required 0/0", bus.auto_active, bus.dir_right);
      failures++;
    end
    for (int i = 0; i < 3; i++) begin
      pulse_keys(3'b100);
      checks++;
      if ({bus.auto_active, bus.dir_right} !== exp_ad[i] || bus.position !== 3'd0) begin
        $display("FAIL mode_cycle i=%0d auto/dir=%b%b pos=%0d required %b/0", i, bus.auto_active, bus.dir_right, bus.position, exp_ad[i]);
        failures++;
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.position !== 3'd0 || bus.step_pulse !== 1'b0) begin
        $display("FAIL manual_no_step cyc=%0d pos=%0d step=%b required 0/0", c, bus.position, bus.step_pulse);
        failures++;
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_keys(3'b001);
    pulse_keys(3'b001);
    pulse_keys(3'b100);
    pulse_keys(3'b100);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.position !== 3'd2 || bus.dir_right !== 1'b1) begin
      $display("FAIL pre_reset pos=%0d dir=%b required 2/1", bus.position, bus.dir_right);
      failures++;
    end
    reset = 1'b1;
    set_keys(3'b001);
    @(posedge clk); #1;
    checks++;
    if (bus.position !== 3'd0 || bus.auto_active !== 1'b0 || bus.dir_right !== 1'b0 || bus.step_pulse !== 1'b0) begin
      $display("FAIL mid_reset pos=%0d auto=%b dir=%b step=%b required 0/0/0/0",
               bus.position, bus.auto_active, bus.dir_right, bus.step_pulse);
      failures++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (c == 8) begin
        @(negedge clk); set_keys(3'b000);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.position !== 3'd0 || bus.auto_active !== 1'b0 || bus.step_pulse !== 1'b0) begin
        $display("FAIL held_key_reset cyc=%0d pos=%0d auto=%b step=%b required 0/0/0",
                 c, bus.position, bus.auto_active, bus.step_pulse);
        failures++;
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] low = 3'b000;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (bus.position !== 3'(m_pos) || bus.auto_active !== (m_mode != 0) ||
          bus.dir_right !== (m_mode == 2) || bus.step_pulse !== m_step) begin
        $display("FAIL random cyc=%0d pos=%0d auto=%b dir=%b step=%b required %0d/%0b/%0b/%0b",
                 c, bus.position, bus.auto_active, bus.dir_right, bus.step_pulse,
                 m_pos, m_mode != 0, m_mode == 2, m_step);
        failures++;
      end
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(3, 0) == 0) low[k] = ~low[k];
      end
      set_keys(low);
      reset = ($urandom_range(79, 0) == 0);
    end
    @(negedge clk); reset = 1'b0; set_keys(3'b000);
  endtask

  initial begin
    set_keys(3'b000);
    test_reset();
    test_manual();
    test_simultaneous();
    test_auto();
    test_mode_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
